// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencing control path.
//   FFT_N / LOG2N / N_PAIRS : default transform geometry (1024-point)
//   state_t, ST_*           : sequencer state encoding, also used by the bench
package fft_pkg;

   localparam int FFT_N   = 1024;
   localparam int LOG2N   = $clog2(FFT_N);
   localparam int N_PAIRS = FFT_N / 2;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fft_valid_delay.sv
// Fixed-depth delay line for valid/tag bits, used to align control with the
// butterfly datapath latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : synchronous clear of every stage
//   i_d        : WIDTH-bit input, o_q : the same bits DEPTH cycles later
module fft_valid_delay #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe <= '0;
      end else if (i_flush) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int k = 1; k < DEPTH; k++) begin
            r_pipe[k] <= r_pipe[k-1];
         end
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Stage/pair sequencer for an in-place radix-2 FFT. Issues one butterfly pair
// per clock to the AGU, then drains the butterfly pipeline before the next
// stage so no stage reads a sample its predecessor has not yet written.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_start, i_abort    : transform request (IDLE only), synchronous abort
//   o_busy, o_done      : RUN|DRAIN, one-cycle completion pulse
//   o_stage, o_pair_id  : AGU coordinates, valid when o_issue_valid
//   o_wr_valid/o_wr_last: write-back strobe and last-pair-of-stage marker
//
// state | meaning
// IDLE  | waiting for start, stage/pair held at 0
// RUN   | issuing pairs 0..N/2-1 of the current stage
// DRAIN | PIPE_LAT cycles letting the stage's last writes land
// DONE  | one-cycle completion pulse, then back to IDLE
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int N        = 1024,
   parameter int PIPE_LAT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [$clog2(N)-1:0]   o_stage,
   output logic [$clog2(N)-2:0]   o_pair_id,
   output logic                   o_issue_valid,
   output logic                   o_wr_valid,
   output logic                   o_wr_last
);

   localparam int SW = $clog2(N);
   localparam int PW = SW - 1;
   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [SW-1:0] STAGE_LAST = SW'(SW - 1);
   localparam logic [PW-1:0] PAIR_LAST  = PW'(N / 2 - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT - 1);

   state_t        r_state;
   logic [SW-1:0] r_stage;
   logic [PW-1:0] r_pair;
   logic [DW-1:0] r_drain;

   logic       w_issue_valid;
   logic       w_issue_last;
   logic [1:0] w_wr_tap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_pair  <= '0;
         r_drain <= '0;
      end else if (i_abort) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_pair  <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_RUN;
                  r_stage <= '0;
                  r_pair  <= '0;
               end
            end
            ST_RUN: begin
               if (r_pair == PAIR_LAST) begin
                  r_state <= ST_DRAIN;
                  r_drain <= DRAIN_LOAD;
               end else begin
                  r_pair <= r_pair + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (r_drain == '0) begin
                  if (r_stage == STAGE_LAST) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_RUN;
                     r_stage <= r_stage + 1'b1;
                     r_pair  <= '0;
                  end
               end else begin
                  r_drain <= r_drain - 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_stage <= '0;
               r_pair  <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_issue_valid = (r_state == ST_RUN);
   assign w_issue_last  = w_issue_valid && (r_pair == PAIR_LAST);

   // Abort flushes in-flight write strobes so nothing lands after IDLE.
   fft_valid_delay #(
      .WIDTH (2),
      .DEPTH (PIPE_LAT)
   ) u_valid_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (i_abort),
      .i_d     ({w_issue_valid, w_issue_last}),
      .o_q     (w_wr_tap)
   );

   assign o_busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign o_done        = (r_state == ST_DONE);
   assign o_issue_valid = w_issue_valid;
   assign o_stage       = r_stage;
   assign o_pair_id     = r_pair;
   assign o_wr_valid    = w_wr_tap[1];
   assign o_wr_last     = w_wr_tap[0];

endmodule

// File: tb/tb_fft_sequencer.sv
module tb_fft_sequencer;
   import fft_pkg::*;

   localparam int N     = 8;
   localparam int PL    = 2;
   localparam int LG    = $clog2(N);
   localparam int NP    = N / 2;
   localparam int PER   = NP + PL;
   localparam int TOTAL = LG * PER;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy, done, issue_valid, wr_valid, wr_last;
   logic [2:0] stage;
   logic [1:0] pair_id;

   fft_sequencer #(.N(N), .PIPE_LAT(PL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (start),
      .i_abort       (abort),
      .o_busy        (busy),
      .o_done        (done),
      .o_stage       (stage),
      .o_pair_id     (pair_id),
      .o_issue_valid (issue_valid),
      .o_wr_valid    (wr_valid),
      .o_wr_last     (wr_last)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a transform is a timeline of k = 0..TOTAL cycles after
   // the start edge; each stage occupies PER cycles (NP issues then PL drain).
   int cyc  = 0;
   bit m_act = 0;
   int m_k  = 0;
   int kill = 0;
   bit hist_iv [0:4095];
   bit hist_il [0:4095];
   int wr_cnt = 0;
   int wl_cnt = 0;
   int done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit st, input bit ab);
      bit e_busy, e_done, e_iv, e_il, e_wv, e_wl, e_sp;
      int e_stage, e_pair, r;
      start = st;
      abort = ab;
      @(posedge clk);
      cyc++;
      if (!rst_n || ab) begin
         m_act = 0;
         kill  = cyc;
      end else if (m_act) begin
         if (m_k == TOTAL) m_act = 0;
         else m_k++;
      end else if (st) begin
         m_act = 1;
         m_k   = 0;
      end
      e_busy = 0; e_done = 0; e_iv = 0; e_il = 0; e_sp = 1;
      e_stage = 0; e_pair = 0;
      if (m_act && m_k < TOTAL) begin
         r       = m_k % PER;
         e_busy  = 1;
         e_stage = m_k / PER;
         e_iv    = (r < NP);
         e_pair  = e_iv ? r : NP - 1;
         e_il    = e_iv && (r == NP - 1);
      end else if (m_act) begin
         e_done = 1;
         e_sp   = 0;
      end
      hist_iv[cyc] = e_iv;
      hist_il[cyc] = e_il;
      e_wv = 0; e_wl = 0;
      if (cyc - PL >= 0 && cyc - PL >= kill) begin
         e_wv = hist_iv[cyc-PL];
         e_wl = hist_il[cyc-PL];
      end
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("issue_valid", issue_valid, e_iv);
      chk("wr_valid", wr_valid, e_wv);
      chk("wr_last", wr_last, e_wl);
      if (e_sp) begin
         chk("stage", stage, e_stage);
         chk("pair_id", pair_id, e_pair);
      end
      if (wr_valid) wr_cnt++;
      if (wr_last) wl_cnt++;
      if (done) done_cnt++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_issue"}, issue_valid, 0);
      chk({tag, "_wr_valid"}, wr_valid, 0);
      chk({tag, "_wr_last"}, wr_last, 0);
      chk({tag, "_stage"}, stage, 0);
      chk({tag, "_pair"}, pair_id, 0);
   endtask

   initial begin
      #2;
      chk_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle, then one clean transform with write-back counting.
      repeat (3) step(0, 0);
      wr_cnt = 0; wl_cnt = 0; done_cnt = 0;
      step(1, 0);
      repeat (TOTAL + 2) step(0, 0);
      chk("wr_count", wr_cnt, LG * NP);
      chk("wr_last_count", wl_cnt, LG);
      chk("done_count", done_cnt, 1);

      // Random start pulses while busy must not disturb the sequence.
      done_cnt = 0;
      step(1, 0);
      repeat (TOTAL + 1) step(bit'($urandom_range(0, 1)), 0);
      step(0, 0);
      chk("done_count_noisy", done_cnt, 1);

      // Abort in stage 1 at pair 2, then a fresh clean transform.
      done_cnt = 0;
      step(1, 0);
      while (m_act && m_k < PER + 2) step(0, 0);
      step(0, 1);
      chk("abort_stage", stage, 0);
      chk("abort_pair", pair_id, 0);
      repeat (4) step(0, 0);
      chk("abort_no_done", done_cnt, 0);
      step(1, 0);
      repeat (TOTAL + 2) step(0, 0);
      chk("done_after_abort", done_cnt, 1);

      // Start held high: one transform every TOTAL+2 cycles.
      done_cnt = 0;
      repeat (3 * (TOTAL + 2)) step(1, 0);
      step(0, 0);
      chk("held_start_dones", done_cnt, 3);
      repeat (3) step(0, 0);

      // Asynchronous reset in the first DRAIN cycle, with a write in flight.
      step(1, 0);
      while (m_act && m_k < NP) step(0, 0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_rst");
      step(0, 0);
      rst_n = 1'b1;
      repeat (3) step(0, 0);
      done_cnt = 0;
      step(1, 0);
      repeat (TOTAL + 2) step(0, 0);
      chk("done_after_reset", done_cnt, 1);

      // Randomized start/abort traffic against the model.
      repeat (300) step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 39) == 0));
      step(0, 1);
      repeat (3) step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
